// File: rtl/dcache_tag_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_tag_ctrl
//
// Sequencing and arbitration controller for the single-port data-cache tag
// store SRAM. The load-lookup, refill-write and invalidate paths share the
// port. After reset, and on request, the block walks every index and writes
// zero to it. The SRAM contents are not reset, so this walk is what clears
// the valid bits.
//
// The SRAM captures its address on the falling clock edge and reads
// asynchronously. A granted lookup therefore returns data in the same cycle.
// Writes are byte-enabled and take effect on the rising edge.
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   flush_i                   request a full valid-bit clear (IDLE only)
//   busy_o                    high while the INIT or FLUSH walk runs
//   flush_done_o              pulses on the last write of a FLUSH walk
//   ld_req_i/idx_i/tag_i      lookup request, index and compare tag
//   ld_gnt_o                  lookup granted this cycle
//   ld_hit_o, ld_rtag_o       hit flag and stored tag (valid with ld_gnt_o)
//   refill_req_i/idx_i/tag_i  write a valid tag
//   refill_gnt_o              refill accepted this cycle
//   inv_req_i/idx_i           clear the valid bit of one index
//   inv_gnt_o                 invalidate accepted this cycle
//   ts_en_o, ts_we_o, ts_be_o tag store enable, write enable, byte enables
//   ts_addr_o, ts_wdata_o     tag store index and write data
//   ts_rdata_i                tag store read data
// ---------------------------------------------------------------------------
module dcache_tag_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_WORDS    = 256,
    parameter int TAG_WIDTH    = 20,
    parameter int VALID_POS    = 31,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    output logic                         busy_o,
    output logic                         flush_done_o,
    input  logic                         ld_req_i,
    input  logic [$clog2(NUM_WORDS)-1:0] ld_idx_i,
    input  logic [TAG_WIDTH-1:0]         ld_tag_i,
    output logic                         ld_gnt_o,
    output logic                         ld_hit_o,
    output logic [TAG_WIDTH-1:0]         ld_rtag_o,
    input  logic                         refill_req_i,
    input  logic [$clog2(NUM_WORDS)-1:0] refill_idx_i,
    input  logic [TAG_WIDTH-1:0]         refill_tag_i,
    output logic                         refill_gnt_o,
    input  logic                         inv_req_i,
    input  logic [$clog2(NUM_WORDS)-1:0] inv_idx_i,
    output logic                         inv_gnt_o,
    output logic                         ts_en_o,
    output logic                         ts_we_o,
    output logic [DATA_WIDTH/8-1:0]      ts_be_o,
    output logic [$clog2(NUM_WORDS)-1:0] ts_addr_o,
    output logic [DATA_WIDTH-1:0]        ts_wdata_o,
    input  logic [DATA_WIDTH-1:0]        ts_rdata_i
);

    localparam int IDX_W    = $clog2(NUM_WORDS);
    localparam int SC_W     = $clog2(STARVE_LIMIT + 1);
    localparam int INV_BYTE = VALID_POS / 8;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_FLUSH
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic [IDX_W-1:0]  addr_q, addr_d;

    // Only the valid bit and the tag field of the stored word are looked at.
    logic rdata_unused;
    assign rdata_unused = ^ts_rdata_i;

    // Lookup results come straight from the asynchronous read data. They are
    // only meaningful while ld_gnt_o is high.
    assign ld_rtag_o = ts_rdata_i[TAG_WIDTH-1:0];
    assign ld_hit_o  = ts_rdata_i[VALID_POS] && (ts_rdata_i[TAG_WIDTH-1:0] == ld_tag_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            starve_q <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        starve_d     = starve_q;
        busy_o       = 1'b0;
        flush_done_o = 1'b0;
        ld_gnt_o     = 1'b0;
        refill_gnt_o = 1'b0;
        inv_gnt_o    = 1'b0;
        ts_en_o      = 1'b0;
        ts_we_o      = 1'b0;
        ts_be_o      = '0;
        ts_addr_o    = addr_q;
        ts_wdata_o   = '0;

        unique case (state_q)
            ST_INIT, ST_FLUSH: begin
                busy_o     = 1'b1;
                ts_en_o    = 1'b1;
                ts_we_o    = 1'b1;
                ts_be_o    = '1;
                ts_wdata_o = '0;
                ts_addr_o  = cnt_q;
                starve_d   = '0;
                if (cnt_q == IDX_W'(NUM_WORDS - 1)) begin
                    cnt_d        = '0;
                    state_d      = ST_IDLE;
                    flush_done_o = (state_q == ST_FLUSH);
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end

            ST_IDLE: begin
                if (flush_i) begin
                    state_d = ST_FLUSH;
                end else if (ld_req_i &&
                             ((starve_q == SC_W'(STARVE_LIMIT)) || (!refill_req_i && !inv_req_i))) begin
                    ld_gnt_o  = 1'b1;
                    ts_en_o   = 1'b1;
                    ts_addr_o = ld_idx_i;
                end else if (refill_req_i) begin
                    refill_gnt_o                   = 1'b1;
                    ts_en_o                        = 1'b1;
                    ts_we_o                        = 1'b1;
                    ts_be_o                        = '1;
                    ts_wdata_o[VALID_POS]          = 1'b1;
                    ts_wdata_o[TAG_WIDTH-1:0]      = refill_tag_i;
                    ts_addr_o                      = refill_idx_i;
                end else if (inv_req_i) begin
                    inv_gnt_o         = 1'b1;
                    ts_en_o           = 1'b1;
                    ts_we_o           = 1'b1;
                    ts_be_o[INV_BYTE] = 1'b1;
                    ts_addr_o         = inv_idx_i;
                end

                // Saturates so a denied cycle at the limit (flush sampled)
                // cannot wrap the counter back to low priority.
                if (ld_req_i && !ld_gnt_o) begin
                    if (starve_q != SC_W'(STARVE_LIMIT)) begin
                        starve_d = starve_q + SC_W'(1);
                    end
                end else begin
                    starve_d = '0;
                end
            end

            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase

        // Index held when idle keeps the SRAM read data stable.
        addr_d = ts_en_o ? ts_addr_o : addr_q;
    end

endmodule

// File: doc/dcache_tag_ctrl.md
Name: dcache_tag_ctrl

Overview:
Sequencing and arbitration controller for the data-cache tag store SRAM. The tag store has a single port: the address is captured on the falling clock edge, the read is asynchronous, and writes are byte-enabled on the rising edge. This block shares that port between the load-lookup path, the refill (miss-handler) write path and the invalidate path. It also runs the post-reset and on-demand valid-bit clear walk, because the SRAM contents are not reset in synthesis.

Parameters:
DATA_WIDTH, 32, tag store word width; must be a multiple of 8.
NUM_WORDS, 256, number of cache indexes; must be a power of 2.
TAG_WIDTH, 20, tag field width; occupies word bits [TAG_WIDTH-1:0]; must be less than VALID_POS.
VALID_POS, 31, bit position of the valid bit inside the word.
STARVE_LIMIT, 4, consecutive denied load-request cycles before the load path is promoted.

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  request a full valid-bit clear (sampled in IDLE only)
busy_o  out  1  high while INIT or FLUSH is running
flush_done_o  out  1  one-cycle pulse on the last write of a FLUSH walk
ld_req_i  in  1  tag lookup request
ld_idx_i  in  log2(NUM_WORDS)  lookup index
ld_tag_i  in  TAG_WIDTH  tag to compare
ld_gnt_o  out  1  lookup granted this cycle
ld_hit_o  out  1  stored valid bit AND stored tag == ld_tag_i; meaningful only when ld_gnt_o=1
ld_rtag_o  out  TAG_WIDTH  stored tag
refill_req_i  in  1  write a valid tag
refill_idx_i  in  log2(NUM_WORDS)  refill index
refill_tag_i  in  TAG_WIDTH  refill tag
refill_gnt_o  out  1  refill accepted this cycle
inv_req_i  in  1  invalidate one index
inv_idx_i  in  log2(NUM_WORDS)  invalidate index
inv_gnt_o  out  1  invalidate accepted this cycle
ts_en_o  out  1  tag store enable
ts_we_o  out  1  tag store write enable
ts_be_o  out  DATA_WIDTH/8  byte enables
ts_addr_o  out  log2(NUM_WORDS)  tag store index
ts_wdata_o  out  DATA_WIDTH  write data
ts_rdata_i  in  DATA_WIDTH  tag store read data

Behaviour:
- Reset values:
  - State: INIT. Walk counter: 0. Starvation counter: 0.
  - Outputs: busy_o=1; all grant outputs 0; flush_done_o=0.
  - Tag store outputs are decoded from state, so they show INIT values.
- FSM states: INIT, IDLE, FLUSH.
- INIT and FLUSH walk:
  - Each cycle drives ts_en_o=1, ts_we_o=1, ts_be_o all-ones, ts_wdata_o=0, ts_addr_o=counter.
  - The counter increments by 1 per cycle; a walk takes exactly NUM_WORDS cycles.
  - On the cycle with counter=NUM_WORDS-1: counter wraps to 0 and the state moves to IDLE.
  - FLUSH additionally pulses flush_done_o on that final cycle; INIT does not.
  - All grant outputs are 0 and all requests are ignored during a walk.
- IDLE: flush_i=1 moves to FLUSH on the next cycle. No grant is issued in the cycle flush_i is sampled.
- IDLE arbitration, one access per cycle. Default priority: refill > invalidate > load.
- Starvation promotion:
  - The starvation counter increments on each cycle where ld_req_i=1 and ld_gnt_o=0 in IDLE.
  - It clears on ld_gnt_o=1, or whenever ld_req_i=0.
  - When it equals STARVE_LIMIT, load takes top priority for that cycle.
- Refill grant: we=1; ts_be_o all-ones; ts_wdata_o has the valid bit = 1, bits [TAG_WIDTH-1:0] = refill_tag_i, all other bits 0.
- Invalidate grant: we=1; ts_be_o one-hot at byte VALID_POS/8; ts_wdata_o=0.
- Load grant:
  - ts_en_o=1, ts_we_o=0, ts_addr_o=ld_idx_i.
  - ld_hit_o and ld_rtag_o are combinational from ts_rdata_i in the same cycle. The falling-edge address capture gives zero-cycle latency.
- No request granted: ts_en_o=0. ts_addr_o holds its last value, so the read data stays stable.
- Read-after-write: a write at index X in cycle N is visible to a lookup at X in cycle N+1.
- A lookup and a write can never be granted in the same cycle.
- Reset asserted mid-walk or mid-access: the FSM returns to INIT and the walk restarts at index 0.
- Requesters hold req and payload stable until they see their grant.

Test Plan:
1. Release reset with all requests low -> busy_o=1 for exactly 256 cycles; ts_addr_o steps 0..255 with we=1 and wdata=0; then IDLE and busy_o=0.
2. After INIT: refill idx=5, tag=0xABCDE; next cycle load idx=5, tag=0xABCDE -> ld_gnt_o=1 and ld_hit_o=1 in that cycle; load with tag=0x12345 -> ld_hit_o=0, ld_rtag_o=0xABCDE.
3. Invalidate idx=5 -> ts_be_o=4'b1000, wdata=0; a following load idx=5 -> ld_hit_o=0.
4. Hold ld_req_i and refill_req_i high continuously -> load is denied 4 cycles, granted on the 5th, then refill resumes; the starvation counter is back at 0.
5. flush_i in IDLE -> 256 write cycles, flush_done_o high only on the cycle with ts_addr_o=255; all loads afterwards miss.
6. Assert rst_ni low at counter=100 during FLUSH -> grants are 0 and, once released, the INIT walk restarts at index 0 with flush_done_o never pulsed.
